// File: rtl/stack_pkg.sv
// Shared constants and command encoding for the processor's LIFO stack.
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 16;
  // Occupancy counter needs one extra bit so that a full stack (count == DEPTH) is representable.
  localparam int STACK_CNT_W = $clog2(STACK_DEPTH) + 1;

  // Command formed as {push, pop}.
  typedef enum logic [1:0] {
    NOP  = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    SWAP = 2'b11
  } stack_cmd_e;

endpackage

// File: rtl/stack_unit_if.sv
// Control-unit <-> stack bus.
// Strobe semantics: push/pop/flush/clear_err are single-cycle strobes with no
// back-pressure; the stack always accepts them on the next rising edge.
// pop_valid is a one-cycle pulse meaning data_out carries a freshly popped word.
interface stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, flush, clear_err, data_in,
    input  data_out, pop_valid, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clear_err, data_in,
    output data_out, pop_valid, top, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the counter defines which entries are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack for the 16-bit processor: counter, status flags and pop output
// registers around a register-array store. The read port always points at the
// current top entry, so one port serves both the top peek and the pop read.
module stack_unit
  import stack_pkg::*;
#(
  parameter int  WIDTH = STACK_WIDTH,
  parameter int  DEPTH = STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  stack_unit_if.slave bus
);

  stack_cmd_e       cmd;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             pop_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             full_w;
  logic             empty_w;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    free_idx;
  logic [WIDTH-1:0] rd_data;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic             ovf_set;
  logic             unf_set;

  assign cmd      = stack_cmd_e'({bus.push, bus.pop});
  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign empty_w  = (count_q == '0);
  // Index of the top entry (count-1) and of the next free slot (count), both truncated.
  assign top_idx  = AW'(count_q - CNT_W'(1));
  assign free_idx = AW'(count_q);

  // Write-port control: a plain push fills the free slot, a swap overwrites the top.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = free_idx;
    if (reset && !bus.flush) begin
      unique case (cmd)
        PUSH: begin
          ram_we    = !full_w;
          ram_waddr = free_idx;
        end
        SWAP: begin
          ram_we    = !empty_w;
          ram_waddr = top_idx;
        end
        default: ;
      endcase
    end
  end

  // New error events; flush masks them, swap never raises either.
  always_comb begin
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!bus.flush) begin
      ovf_set = (cmd == PUSH) && full_w;
      unf_set = (cmd == POP)  && empty_w;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.data_in),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  // Occupancy counter and pop output registers; the old top is read before a swap writes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      data_out_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= 1'b0;
      if (bus.flush) begin
        count_q <= '0;
      end else begin
        unique case (cmd)
          PUSH: begin
            if (!full_w) count_q <= count_q + CNT_W'(1);
          end
          POP: begin
            if (!empty_w) begin
              data_out_q  <= rd_data;
              count_q     <= count_q - CNT_W'(1);
              pop_valid_q <= 1'b1;
            end
          end
          SWAP: begin
            data_out_q  <= empty_w ? bus.data_in : rd_data;
            pop_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags; a fresh error beats clear_err in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_set | (overflow_q  & ~bus.clear_err);
      underflow_q <= unf_set | (underflow_q & ~bus.clear_err);
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.top       = empty_w ? '0 : rd_data;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios plus random traffic against a queue-based LIFO model.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int W     = STACK_WIDTH;
  localparam int D     = STACK_DEPTH;
  localparam int CNT_W = STACK_CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();

  stack_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] model_q[$];     // index 0 = bottom, last = top
  logic [W-1:0] m_dout;
  logic         m_pv;
  logic         m_ovf;
  logic         m_unf;
  logic [W-1:0] exp_q[$];       // expected popped words, in order

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_top();
    return (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
  endfunction

  // Apply one cycle of stack rules to the model.
  task automatic model_apply(input logic p, input logic q, input logic f, input logic c,
                             input logic [W-1:0] d);
    logic new_o, new_u;
    logic [W-1:0] w;
    new_o = 1'b0;
    new_u = 1'b0;
    m_pv  = 1'b0;
    if (f) begin
      model_q.delete();
    end else if (p && !q) begin
      if (model_q.size() < D) model_q.push_back(d);
      else new_o = 1'b1;
    end else if (q && !p) begin
      if (model_q.size() > 0) begin
        w = model_q.pop_back();
        m_dout = w;
        m_pv = 1'b1;
        exp_q.push_back(w);
      end else begin
        new_u = 1'b1;
      end
    end else if (p && q) begin
      if (model_q.size() > 0) begin
        w = model_q[model_q.size()-1];
        model_q[model_q.size()-1] = d;
      end else begin
        w = d;
      end
      m_dout = w;
      m_pv = 1'b1;
      exp_q.push_back(w);
    end
    m_ovf = new_o | (m_ovf & ~c);
    m_unf = new_u | (m_unf & ~c);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_dout = '0;
    m_pv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".count"},     32'(bus.count),     32'(model_q.size()));
    chk({tag, ".full"},      32'(bus.full),      32'(model_q.size() == D));
    chk({tag, ".empty"},     32'(bus.empty),     32'(model_q.size() == 0));
    chk({tag, ".top"},       32'(bus.top),       32'(model_top()));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    chk({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(m_pv));
    chk({tag, ".data_out"},  32'(bus.data_out),  32'(m_dout));
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one command for the next edge and checks the result.
  task automatic step(input string tag, input logic p, input logic q, input logic f,
                      input logic c, input logic [W-1:0] d);
    bus.push      = p;
    bus.pop       = q;
    bus.flush     = f;
    bus.clear_err = c;
    bus.data_in   = d;
    model_apply(p, q, f, c, d);
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
    check_status(tag);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("mon.unexpected_pop_valid", 32'(bus.data_out), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("mon.pop_data", 32'(bus.data_out), 32'(e));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
    bus.data_in   = '0;
    model_reset();

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check_status("reset_held");
    reset = 1'b1;
    step("reset_idle", 0, 0, 0, 0, '0);

    // LIFO order.
    step("lifo_push1", 1, 0, 0, 0, 16'h1111);
    step("lifo_push2", 1, 0, 0, 0, 16'h2222);
    step("lifo_push3", 1, 0, 0, 0, 16'h3333);
    step("lifo_pop1",  0, 1, 0, 0, '0);
    chk("lifo.first_pop", 32'(bus.data_out), 32'h3333);
    step("lifo_pop2",  0, 1, 0, 0, '0);
    step("lifo_pop3",  0, 1, 0, 0, '0);
    chk("lifo.last_pop", 32'(bus.data_out), 32'h1111);

    // Fill, then overflow.
    for (int i = 0; i < D; i++) step("fill", 1, 0, 0, 0, W'(i));
    chk("fill.full", 32'(bus.full), 32'd1);
    step("ovf_push", 1, 0, 0, 0, 16'hBEEF);
    chk("ovf.top_kept", 32'(bus.top), 32'h000F);
    chk("ovf.set", 32'(bus.overflow), 32'd1);
    step("ovf_clear", 0, 0, 0, 1, '0);
    // Swap on a full stack must not overflow.
    step("full_swap", 1, 1, 0, 0, 16'hC0DE);

    // Underflow on empty.
    step("flush_all", 0, 0, 1, 0, '0);
    step("unf_pop", 0, 1, 0, 0, '0);
    chk("unf.set", 32'(bus.underflow), 32'd1);
    step("unf_pop_clr", 0, 1, 0, 1, '0);
    step("unf_clear", 0, 0, 0, 1, '0);

    // Simultaneous push+pop.
    step("swap_seed", 1, 0, 0, 0, 16'hAAAA);
    step("swap_one",  1, 1, 0, 0, 16'h5555);
    chk("swap.old_top", 32'(bus.data_out), 32'hAAAA);
    step("swap_flush", 0, 0, 1, 0, '0);
    step("swap_empty", 1, 1, 0, 0, 16'h7777);
    chk("bypass.data", 32'(bus.data_out), 32'h7777);

    // Flush wins over push.
    for (int i = 0; i < 4; i++) step("flush_fill", 1, 0, 0, 0, W'($urandom_range(0, 65535)));
    step("flush_push", 1, 0, 1, 0, 16'hDEAD);
    step("flush_after", 1, 0, 0, 0, 16'h0042);

    // Asynchronous reset mid-cycle, while pop_valid is high.
    step("ar_push1", 1, 0, 0, 0, 16'h0101);
    step("ar_push2", 1, 0, 0, 0, 16'h0202);
    step("ar_pop",   0, 1, 0, 0, '0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst.count",     32'(bus.count),     32'd0);
    chk("async_rst.pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("async_rst.data_out",  32'(bus.data_out),  32'd0);
    chk("async_rst.empty",     32'(bus.empty),     32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_status("post_reset");

    // Random traffic, push-heavy then pop-heavy.
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 250; n++) begin
        int r;
        logic p, q, f, c;
        r = $urandom_range(0, 99);
        if (phase == 0) begin
          p = (r < 50) || (r >= 80 && r < 92);
          q = (r >= 50 && r < 80) || (r >= 80 && r < 92);
        end else begin
          p = (r < 25) || (r >= 80 && r < 92);
          q = (r >= 25 && r < 80) || (r >= 80 && r < 92);
        end
        f = ($urandom_range(0, 39) == 0);
        c = ($urandom_range(0, 9) == 0);
        step("rand", p, q, f, c, W'($urandom_range(0, 65535)));
      end
    end

    // Let the monitor drain, then confirm nothing was left unobserved.
    step("drain", 0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    chk("scoreboard.leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO stack for the 16-bit processor.
- Responds to the push and pop strobes that the control unit issues: push in its store/push state, pop in its pop-to-X/Y states.
- Returns popped data with a registered valid pulse, and reports full, empty and sticky overflow/underflow status.
- Sits between the control unit, the accumulator result bus (push data) and the X/Y operand load path (pop data).

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- push  input  1  push strobe; one cycle per push.
- pop  input  1  pop strobe; one cycle per pop.
- flush  input  1  synchronous stack clear, driven from the control unit's reset/idle state.
- clear_err  input  1  synchronous clear of the overflow and underflow flags.
- data_in  input  WIDTH  word to push.
- data_out  output  WIDTH  registered popped word.
- pop_valid  output  1  one-cycle pulse; data_out holds newly popped data.
- top  output  WIDTH  combinational peek of the top entry; 0 when empty.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH (combinational).
- empty  output  1  count == 0 (combinational).
- overflow  output  1  sticky; set when a push is attempted while full.
- underflow  output  1  sticky; set when a pop is attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous) clears count, data_out, pop_valid, overflow and underflow to 0. Memory contents are not reset. While reset is held, no writes occur.
- pop_valid defaults to 0 every cycle. It is 1 only in the cycle after an accepted pop.
- Priority per cycle: flush, then the push/pop combination.
- flush=1: count<=0 and pop_valid<=0. push and pop are ignored that cycle; no error flags are set.
- push only:
  - count<DEPTH: mem[count]<=data_in, count<=count+1.
  - full: write is dropped, count unchanged, overflow<=1.
- pop only:
  - count>0: data_out<=mem[count-1], count<=count-1, pop_valid<=1.
  - empty: data_out and count unchanged, pop_valid stays 0, underflow<=1.
- push and pop together:
  - count>0: data_out<=mem[count-1] (old value), mem[count-1]<=data_in, count unchanged, pop_valid<=1. Read happens before write.
  - count==0: bypass. data_out<=data_in, pop_valid<=1, count stays 0, no underflow.
  - A full stack does not overflow in this case.
- Error flags:
  - clear_err=1 clears overflow and underflow.
  - A new error in the same cycle as clear_err wins, so the flag stays/becomes 1.
  - flush does not touch the error flags.
- Latency:
  - Pop data and pop_valid appear 1 cycle after the strobe.
  - A pushed word is visible on top the cycle after the push edge.
  - Back-to-back push/pop on consecutive cycles is supported at full rate with no stall.
- Counter arithmetic uses CNT_W bits; count never exceeds DEPTH and never wraps below 0. Memory index is count-1 truncated to $clog2(DEPTH) bits.
- top = mem[count-1] when count>0, else 0.

Decomposition:
- Package stack_pkg:
  - STACK_WIDTH=16 and STACK_DEPTH=16 defaults.
  - A localparam for CNT_W derivation.
  - The command encoding {push,pop} as 2-bit constants: NOP=2'b00, POP=2'b01, PUSH=2'b10, SWAP=2'b11.
- Sub-module stack_ram:
  - DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, used for both the top peek and the pop read.
  - stack_unit owns the counter, flags and output registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> count=0, empty=1, full=0, data_out=0, pop_valid=0, overflow=0, underflow=0.
- LIFO order: push 0x1111, 0x2222, 0x3333, then 3 pops -> data_out 0x3333, 0x2222, 0x1111 on the 3 cycles after each pop, pop_valid=1 each time; count 3->0.
- Full/overflow: push 16 words 0x0000..0x000F -> full=1, count=16, top=0x000F. A 17th push 0xBEEF -> count=16, overflow=1, top=0x000F. Then clear_err -> overflow=0.
- Empty/underflow: pop when empty -> pop_valid=0, underflow=1, data_out unchanged. Then pop together with clear_err on an empty stack -> underflow stays 1.
- Simultaneous push+pop:
  - With stack [0xAAAA] and data_in=0x5555 -> data_out=0xAAAA, pop_valid=1, count=1, top=0x5555.
  - On an empty stack with data_in=0x7777 -> data_out=0x7777, pop_valid=1, count=0, underflow=0.
- Flush and mid-operation reset:
  - Push 4 words, then assert flush together with push -> count=0, no write.
  - Push 2 words, then drive reset=0 asynchronously mid-cycle -> count=0 and pop_valid=0 immediately, before the next clock edge.
